muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the single clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request pulse; operands and op are sampled when accepted.
REQ-005 SHALL have port MDCtl  input  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU (RV32M funct3).
REQ-006 SHALL have port SrcA  input  WIDTH  first operand (multiplicand / dividend).
REQ-007 SHALL have port SrcB  input  WIDTH  second operand (multiplier / divisor).
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; MDResult is valid from this cycle on.
REQ-010 SHALL have port MDResult  output  WIDTH  registered result.

Function
REQ-011 SHALL implement the FSM states IDLE, BUSY and DONE; all outputs are registered.
REQ-012 SHALL accept start only in IDLE or DONE; at the accepting edge t0 it latches SrcA, SrcB and MDCtl and enters BUSY; busy=1 from t0.
REQ-013 SHALL ignore start while BUSY; the latched operands and op are unaffected.
REQ-014 SHALL, for multiply, take the magnitudes of the operands (signed: MULH both operands; MULHSU SrcA only), run radix-2 shift-add with one bit per cycle for WIDTH cycles into a 2*WIDTH product, then negate the product if the operand signs differ.
REQ-015 SHALL return the low WIDTH product bits for MUL and the high WIDTH bits for MULH, MULHSU and MULHU.
REQ-016 SHALL, for divide, run restoring division on the magnitudes for WIDTH cycles; for DIV, negate the quotient if the signs differ; for REM, give the remainder the sign of the dividend.
REQ-017 SHALL, for a normal operation, enter DONE at edge t0+WIDTH with done=1, busy=0, and MDResult updated at that same edge.
REQ-018 SHALL, on divide by zero, skip the iteration: enter DONE at t0+1; quotient = all ones (DIV and DIVU); remainder = dividend (REM and REMU).
REQ-019 SHALL, on signed overflow (DIV/REM with SrcA = most negative value and SrcB = -1), enter DONE at t0+1; quotient = most negative value; remainder = 0.
REQ-020 SHALL hold done for exactly one cycle, then return to IDLE unless start is high in DONE, which is accepted as a new t0.
REQ-021 SHALL hold MDResult stable from DONE until the next completion; it SHALL NOT change during BUSY.
REQ-022 SHALL perform all arithmetic modulo 2^WIDTH (2^(2*WIDTH) for the product); no exceptions are raised.

Reset
REQ-023 SHALL, on reset assertion, immediately force state=IDLE, busy=0, done=0, MDResult=0 and clear all internal registers.
REQ-024 SHALL, on reset asserted mid-operation, abandon the operation; no done is produced for it.
REQ-025 SHALL accept start on the first rising edge after reset deasserts.

Verification
REQ-026 MUL SrcA=7, SrcB=0xFFFFFFFD -> done at t0+32, MDResult=0xFFFFFFEB; busy high for exactly 32 cycles.
REQ-027 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-028 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
REQ-029 DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 with REM -> 0; each done at t0+1.
REQ-030 start re-pulsed at t0+5 with different operands -> ignored; result matches the first request. Back-to-back start in the DONE cycle -> second result follows 32 cycles later.
REQ-031 reset at t0+10 -> busy=0, done=0, MDResult=0 immediately; no done pulse; the next MUL 3x4 -> 12.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Latency WIDTH cycles from accept to done, or 1 cycle for divide-by-zero and signed overflow; start is ignored while busy.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDCtl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] MDResult
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [2:0]         op;
  logic [WIDTH-1:0]   a;
  logic [2*WIDTH-1:0] p;
  logic               neg;
  logic               skip;
  logic [CW-1:0]      cnt;

  // Operand decode at the accepting edge: MULH/MULHSU/DIV/REM treat SrcA as signed; MULH/DIV/REM treat SrcB as signed.
  logic             a_sgn, b_sgn, a_neg, b_neg, is_div, div_zero, ovf, neg_in;
  logic [WIDTH-1:0] a_mag, b_mag, special_res;

  assign is_div   = MDCtl[2];
  assign a_sgn    = (MDCtl == 3'd1) || (MDCtl == 3'd2) || (MDCtl == 3'd4) || (MDCtl == 3'd6);
  assign b_sgn    = (MDCtl == 3'd1) || (MDCtl == 3'd4) || (MDCtl == 3'd6);
  assign a_neg    = a_sgn & SrcA[WIDTH-1];
  assign b_neg    = b_sgn & SrcB[WIDTH-1];
  assign a_mag    = a_neg ? -SrcA : SrcA;
  assign b_mag    = b_neg ? -SrcB : SrcB;
  assign div_zero = is_div && (SrcB == '0);
  assign ovf      = is_div && !MDCtl[0] && (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);
  assign neg_in   = (is_div && MDCtl[1]) ? a_neg : (a_neg ^ b_neg);
  assign special_res = div_zero ? (MDCtl[1] ? SrcA : '1) : (MDCtl[1] ? '0 : SrcA);

  // One iteration step. p holds {product high, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  logic [WIDTH:0]     mul_sum, rem_sh, rem_sub;
  logic               ge;
  logic [2*WIDTH-1:0] mul_next, div_next, p_next, prod;
  logic [WIDTH-1:0]   quo, rem;
  logic [WIDTH-1:0]   result;

  assign mul_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, a} : {(WIDTH+1){1'b0}});
  assign mul_next = {mul_sum, p[WIDTH-1:1]};
  assign rem_sh   = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
  assign ge       = rem_sh >= {1'b0, a};
  assign rem_sub  = rem_sh - {1'b0, a};
  assign div_next = {(ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0]), p[WIDTH-2:0], ge};
  assign p_next   = op[2] ? div_next : mul_next;

  assign prod = neg ? -p_next : p_next;
  assign quo  = neg ? -p_next[WIDTH-1:0] : p_next[WIDTH-1:0];
  assign rem  = neg ? -p_next[2*WIDTH-1:WIDTH] : p_next[2*WIDTH-1:WIDTH];

  always_comb begin
    result = '0;
    case (op)
      3'd0:                result = prod[WIDTH-1:0];
      3'd1, 3'd2, 3'd3:    result = prod[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:          result = quo;
      default:             result = rem;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op       <= '0;
      a        <= '0;
      p        <= '0;
      neg      <= 1'b0;
      skip     <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      MDResult <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            op    <= MDCtl;
            a     <= is_div ? b_mag : a_mag;
            neg   <= neg_in;
            skip  <= div_zero || ovf;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= BUSY;
            if (div_zero || ovf)
              p <= {{WIDTH{1'b0}}, special_res};
            else
              p <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (skip) begin
            MDResult <= p[WIDTH-1:0];
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            p   <= p_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH-1)) begin
              MDResult <= result;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, special cases, ignored restart, back-to-back and mid-op reset.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  MDCtl = '0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        busy, done;
  logic [31:0] MDResult;

  int pass_cnt = 0;
  int total = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .MDCtl(MDCtl),
    .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done), .MDResult(MDResult)
  );

  always #5 clk = ~clk;

  // Drive one request and wait (bounded) for done; now=1 drives immediately instead of at the next negedge.
  task automatic issue(input bit now, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output int bc);
    if (!now) @(negedge clk);
    start = 1'b1; MDCtl = op; SrcA = a; SrcB = b;
    @(posedge clk); #1;
    start = 1'b0;
    bc  = busy ? 1 : 0;
    lat = -1;
    res = 'x;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        res = MDResult;
        break;
      end
      if (busy) bc++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    total++; if (MDResult !== 32'h0) $display("FAIL reset_result got %h want 0", MDResult); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_mul();
    int lat, bc; logic [31:0] res;
    issue(0, 3'd0, 32'd7, 32'hFFFFFFFD, lat, res, bc);
    total++; if (lat !== 32) $display("FAIL mul_latency got %0d want 32", lat); else pass_cnt++;
    total++; if (res !== 32'hFFFFFFEB) $display("FAIL mul_result got %h want ffffffeb", res); else pass_cnt++;
    total++; if (bc !== 32) $display("FAIL mul_busy_cycles got %0d want 32", bc); else pass_cnt++;
  endtask

  task automatic test_mulh();
    int lat, bc; logic [31:0] res;
    issue(0, 3'd1, 32'h80000000, 32'h80000000, lat, res, bc);
    total++; if (res !== 32'h40000000) $display("FAIL mulh_result got %h want 40000000", res); else pass_cnt++;
    total++; if (lat !== 32) $display("FAIL mulh_latency got %0d want 32", lat); else pass_cnt++;
    issue(0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res, bc);
    total++; if (res !== 32'hFFFFFFFF) $display("FAIL mulhsu_result got %h want ffffffff", res); else pass_cnt++;
    issue(0, 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, res, bc);
    total++; if (res !== 32'hFFFFFFFE) $display("FAIL mulhu_result got %h want fffffffe", res); else pass_cnt++;
    issue(0, 3'd2, 32'h00000003, 32'h80000000, lat, res, bc);
    total++; if (res !== 32'h00000001) $display("FAIL mulhsu_pos_result got %h want 00000001", res); else pass_cnt++;
  endtask

  task automatic test_div();
    int lat, bc; logic [31:0] res;
    issue(0, 3'd4, 32'hFFFFFFF9, 32'd2, lat, res, bc);
    total++; if (res !== 32'hFFFFFFFD) $display("FAIL div_result got %h want fffffffd", res); else pass_cnt++;
    total++; if (lat !== 32) $display("FAIL div_latency got %0d want 32", lat); else pass_cnt++;
    issue(0, 3'd6, 32'hFFFFFFF9, 32'd2, lat, res, bc);
    total++; if (res !== 32'hFFFFFFFF) $display("FAIL rem_result got %h want ffffffff", res); else pass_cnt++;
    issue(0, 3'd5, 32'd100, 32'd7, lat, res, bc);
    total++; if (res !== 32'd14) $display("FAIL divu_result got %h want 0000000e", res); else pass_cnt++;
    issue(0, 3'd7, 32'd100, 32'd7, lat, res, bc);
    total++; if (res !== 32'd2) $display("FAIL remu_result got %h want 00000002", res); else pass_cnt++;
    issue(0, 3'd4, 32'd100, 32'hFFFFFFF9, lat, res, bc);
    total++; if (res !== 32'hFFFFFFF2) $display("FAIL div_negdivisor_result got %h want fffffff2", res); else pass_cnt++;
  endtask

  task automatic test_special();
    int lat, bc; logic [31:0] res;
    issue(0, 3'd5, 32'd5, 32'd0, lat, res, bc);
    total++; if (res !== 32'hFFFFFFFF) $display("FAIL divu_zero_result got %h want ffffffff", res); else pass_cnt++;
    total++; if (lat !== 1) $display("FAIL divu_zero_latency got %0d want 1", lat); else pass_cnt++;
    issue(0, 3'd7, 32'd5, 32'd0, lat, res, bc);
    total++; if (res !== 32'd5) $display("FAIL remu_zero_result got %h want 00000005", res); else pass_cnt++;
    total++; if (lat !== 1) $display("FAIL remu_zero_latency got %0d want 1", lat); else pass_cnt++;
    issue(0, 3'd4, 32'h80000000, 32'hFFFFFFFF, lat, res, bc);
    total++; if (res !== 32'h80000000) $display("FAIL div_ovf_result got %h want 80000000", res); else pass_cnt++;
    total++; if (lat !== 1) $display("FAIL div_ovf_latency got %0d want 1", lat); else pass_cnt++;
    issue(0, 3'd6, 32'h80000000, 32'hFFFFFFFF, lat, res, bc);
    total++; if (res !== 32'h0) $display("FAIL rem_ovf_result got %h want 00000000", res); else pass_cnt++;
    total++; if (lat !== 1) $display("FAIL rem_ovf_latency got %0d want 1", lat); else pass_cnt++;
    issue(0, 3'd4, 32'hFFFFFFF9, 32'd0, lat, res, bc);
    total++; if (res !== 32'hFFFFFFFF) $display("FAIL div_zero_result got %h want ffffffff", res); else pass_cnt++;
  endtask

  // Previous result is 0xFFFFFFFF from test_special; it must hold through BUSY.
  task automatic test_ignore();
    int lat; bit held;
    lat = -1; held = 1'b1;
    @(negedge clk);
    start = 1'b1; MDCtl = 3'd0; SrcA = 32'd3; SrcB = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (k == 5) start = 1'b0;
      if (done) begin lat = k; break; end
      if (MDResult !== 32'hFFFFFFFF) held = 1'b0;
      if (k == 4) begin
        start = 1'b1; MDCtl = 3'd5; SrcA = 32'd81; SrcB = 32'd9;
      end
    end
    start = 1'b0;
    total++; if (held !== 1'b1) $display("FAIL ignore_result_stable got %b want 1", held); else pass_cnt++;
    total++; if (lat !== 32) $display("FAIL ignore_latency got %0d want 32", lat); else pass_cnt++;
    total++; if (MDResult !== 32'd15) $display("FAIL ignore_result got %h want 0000000f", MDResult); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic [31:0] res;
    issue(0, 3'd5, 32'd100, 32'd7, lat, res, bc);
    total++; if (res !== 32'd14) $display("FAIL b2b_first_result got %h want 0000000e", res); else pass_cnt++;
    issue(1, 3'd0, 32'd6, 32'd7, lat, res, bc);
    total++; if (bc !== 32) $display("FAIL b2b_busy_cycles got %0d want 32", bc); else pass_cnt++;
    total++; if (lat !== 32) $display("FAIL b2b_latency got %0d want 32", lat); else pass_cnt++;
    total++; if (res !== 32'd42) $display("FAIL b2b_second_result got %h want 0000002a", res); else pass_cnt++;
    @(posedge clk); #1;
    total++; if (done !== 1'b0) $display("FAIL b2b_done_one_cycle got %b want 0", done); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int lat, bc; logic [31:0] res; bit saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    start = 1'b1; MDCtl = 3'd0; SrcA = 32'h0000FFFF; SrcB = 32'h0000FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL midreset_busy got %b want 0", busy); else pass_cnt++;
    total++; if (done !== 1'b0) $display("FAIL midreset_done got %b want 0", done); else pass_cnt++;
    total++; if (MDResult !== 32'h0) $display("FAIL midreset_result got %h want 0", MDResult); else pass_cnt++;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    reset = 1'b0;
    issue(0, 3'd0, 32'd3, 32'd4, lat, res, bc);
    total++; if (saw_done !== 1'b0) $display("FAIL midreset_no_done got %b want 0", saw_done); else pass_cnt++;
    total++; if (lat !== 32) $display("FAIL post_reset_latency got %0d want 32", lat); else pass_cnt++;
    total++; if (res !== 32'd12) $display("FAIL post_reset_result got %h want 0000000c", res); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
